// File: rtl/layer_engine_dispatch_ctrl_pkg.sv
// Shared definitions for the layer engine dispatch controller.
// Holds the one-hot FSM state encodings, the supported engine-count range
// and small helpers used by the optional performance counters
// (enabled with DISPATCH_PERF_CNT_EN).
package layer_engine_dispatch_ctrl_pkg;

  // Supported size of the engine pool.
  localparam int C_MIN_ENGINES = 2;
  localparam int C_MAX_ENGINES = 16;

  // Performance counter widths.
  localparam int C_PERF_CNT_W = 32;
  localparam int C_BUSY_MAX_W = 5;

  // Issue FSM, one-hot encoded.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_ISSUE = 2'b10
  } dispatch_state_t;

  // Saturating increment for the event counters.
  function automatic logic [C_PERF_CNT_W-1:0] sat_inc(input logic [C_PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/layer_engine_dispatch_ctrl_rr_free_picker.sv
// Round-robin free-engine picker.
// Searches the free vector upward starting one past rr_ptr, wrapping modulo
// C_NUM_ENGINES, and returns the first free index. any_free is the OR of
// the free vector; grant is meaningless when any_free is 0.
module layer_engine_dispatch_ctrl_rr_free_picker
  import layer_engine_dispatch_ctrl_pkg::*;
#(
  parameter int C_NUM_ENGINES = 4
) (
  input  logic [C_NUM_ENGINES-1:0]         free,
  input  logic [$clog2(C_NUM_ENGINES)-1:0] rr_ptr,
  output logic [$clog2(C_NUM_ENGINES)-1:0] grant,
  output logic                             any_free
);

  localparam int IW = $clog2(C_NUM_ENGINES);

  logic [IW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest free one wins.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path through the block can leave it holding its old value (no latch).
    grant    = '0;
    cand     = '0;
    any_free = |free;
    for (int k = C_NUM_ENGINES; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % C_NUM_ENGINES);
      if (free[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/layer_engine_dispatch_ctrl.sv
// layer_engine_dispatch_ctrl
// Dispatches decoded command packets to a pool of layer engines. An idle
// engine is picked round-robin, the packet is offered on a shared bus with a
// start/ack handshake, and per-engine busy/pending state plus the command id
// are tracked until the engine's done pulse has been returned as a
// completion record (engine index + command id).
// Optional feature: define DISPATCH_PERF_CNT_EN to add saturating
// performance counters (dispatch count, stall cycles, peak busy engines).
module layer_engine_dispatch_ctrl
  import layer_engine_dispatch_ctrl_pkg::*;
#(
  parameter int C_PACKET_WIDTH = 128,
  parameter int C_NUM_ENGINES  = 4,
  parameter int C_ID_WIDTH     = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_accept,
  input  logic [C_PACKET_WIDTH-1:0]        cmd_data,
  input  logic [C_ID_WIDTH-1:0]            cmd_id,
  output logic [C_NUM_ENGINES-1:0]         eng_start,
  input  logic [C_NUM_ENGINES-1:0]         eng_ack,
  output logic [C_PACKET_WIDTH-1:0]        eng_data,
  input  logic [C_NUM_ENGINES-1:0]         eng_done,
  output logic                             cmpl_valid,
  input  logic                             cmpl_ready,
  output logic [$clog2(C_NUM_ENGINES)-1:0] cmpl_engine,
  output logic [C_ID_WIDTH-1:0]            cmpl_id,
  output logic                             err_spurious
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [C_PERF_CNT_W-1:0]          perf_dispatched,
  output logic [C_PERF_CNT_W-1:0]          perf_stall,
  output logic [C_BUSY_MAX_W-1:0]          perf_busy_max
`endif
);

  localparam int IW = $clog2(C_NUM_ENGINES);

  dispatch_state_t state_q, state_d;

  logic [C_NUM_ENGINES-1:0] busy_q;    // engine has taken a command, not yet done
  logic [C_NUM_ENGINES-1:0] pend_q;    // engine done, completion not yet drained
  logic [C_NUM_ENGINES-1:0] free;
  logic [IW-1:0]            rr_ptr_q;  // last granted engine
  logic [IW-1:0]            grant_q;   // engine being offered the current packet
  logic [IW-1:0]            pick;
  logic                     any_free;
  logic [C_ID_WIDTH-1:0]    id_q [C_NUM_ENGINES];

  logic                     accept_fire;
  logic                     ack_fire;
  logic [C_NUM_ENGINES-1:0] done_ok;
  logic                     err_set;
  logic [C_NUM_ENGINES-1:0] drain_mask;
  logic [C_NUM_ENGINES-1:0] busy_d;
  logic [C_NUM_ENGINES-1:0] pend_d;
  logic [IW-1:0]            sel_d;

  // An engine with an undrained completion is not free, so its id slot and
  // pending bit can never be overwritten before the record leaves.
  assign free = ~busy_q & ~pend_q;

  layer_engine_dispatch_ctrl_rr_free_picker #(
    .C_NUM_ENGINES(C_NUM_ENGINES)
  ) u_picker (
    .free    (free),
    .rr_ptr  (rr_ptr_q),
    .grant   (pick),
    .any_free(any_free)
  );

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs from the same pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Issue FSM next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cmd_accept  = 1'b0;
    accept_fire = 1'b0;
    ack_fire    = 1'b0;
    eng_start   = '0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_accept = any_free && !rst;
        if (cmd_valid && cmd_accept) begin
          accept_fire = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start = {{(C_NUM_ENGINES-1){1'b0}}, 1'b1} << grant_q;
        if (eng_ack[grant_q]) begin
          ack_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy/pending bookkeeping and next completion selection.
  always_comb begin
    // Done is only meaningful for a busy engine; anything else is an error.
    done_ok = eng_done & busy_q;
    // Acks outside the offered engine (or while nothing is offered) and done
    // pulses from non-busy engines are flagged.
    err_set = (|(eng_ack & ~eng_start)) || (|(eng_done & ~busy_q));

    drain_mask = '0;
    if (cmpl_valid && cmpl_ready) drain_mask[cmpl_engine] = 1'b1;

    // The acked engine is not busy and a pending engine is not busy, so the
    // set/clear terms below never collide on one bit.
    busy_d = (busy_q & ~done_ok) | (ack_fire ? eng_start : '0);
    pend_d = (pend_q & ~drain_mask) | done_ok;

    // Lowest pending engine wins.
    sel_d = '0;
    for (int i = C_NUM_ENGINES - 1; i >= 0; i--) begin
      if (pend_d[i]) sel_d = IW'(i);
    end
  end

  // Command id per engine, written at grant time.
  always_ff @(posedge clk) begin
    // NOTE: the id table is not reset; a slot is always written at grant
    // before its pending bit can be set, so its reset value is never observed.
    if (accept_fire) id_q[pick] <= cmd_id;
  end

  // Control registers, issue bus and completion record.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      pend_q       <= '0;
      rr_ptr_q     <= IW'(C_NUM_ENGINES - 1);
      grant_q      <= '0;
      eng_data     <= '0;
      cmpl_valid   <= 1'b0;
      cmpl_engine  <= '0;
      cmpl_id      <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      if (accept_fire) begin
        eng_data <= cmd_data;
        grant_q  <= pick;
        rr_ptr_q <= pick;
      end
      if (err_set) err_spurious <= 1'b1;
      // The presented record is frozen while stalled, even if a lower engine
      // completes meanwhile; otherwise it tracks the lowest pending engine.
      if (!cmpl_valid || cmpl_ready) begin
        cmpl_valid  <= |pend_d;
        cmpl_engine <= sel_d;
        cmpl_id     <= (|pend_d) ? id_q[sel_d] : '0;
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [C_BUSY_MAX_W-1:0] busy_cnt;

  assign busy_cnt = C_BUSY_MAX_W'($countones(busy_q));

  // Saturating dispatch/stall counters and peak busy-engine watermark.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dispatched <= '0;
      perf_stall      <= '0;
      perf_busy_max   <= '0;
    end else begin
      if (ack_fire) perf_dispatched <= sat_inc(perf_dispatched);
      if (cmd_valid && !cmd_accept) perf_stall <= sat_inc(perf_stall);
      if (busy_cnt > perf_busy_max) perf_busy_max <= busy_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_layer_engine_dispatch_ctrl.sv
// Self-checking bench for layer_engine_dispatch_ctrl.
// A behavioural model tracks each engine as FREE / RUNNING / PENDING and
// predicts every output each cycle. Directed scenarios cover the basic
// dispatch, completion ordering, stall, error and reset cases; a randomized
// phase then plays well-behaved engines with random latencies.
module tb_layer_engine_dispatch_ctrl;

  localparam int N  = 4;
  localparam int PW = 128;
  localparam int IDW = 10;

  typedef enum int { E_FREE, E_RUN, E_PEND } eng_state_t;

  logic           clk;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_accept;
  logic [PW-1:0]  cmd_data;
  logic [IDW-1:0] cmd_id;
  logic [N-1:0]   eng_start;
  logic [N-1:0]   eng_ack;
  logic [PW-1:0]  eng_data;
  logic [N-1:0]   eng_done;
  logic           cmpl_valid;
  logic           cmpl_ready;
  logic [1:0]     cmpl_engine;
  logic [IDW-1:0] cmpl_id;
  logic           err_spurious;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]    perf_dispatched;
  logic [31:0]    perf_stall;
  logic [4:0]     perf_busy_max;
`endif

  layer_engine_dispatch_ctrl #(
    .C_PACKET_WIDTH(PW),
    .C_NUM_ENGINES (N),
    .C_ID_WIDTH    (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_accept  (cmd_accept),
    .cmd_data    (cmd_data),
    .cmd_id      (cmd_id),
    .eng_start   (eng_start),
    .eng_ack     (eng_ack),
    .eng_data    (eng_data),
    .eng_done    (eng_done),
    .cmpl_valid  (cmpl_valid),
    .cmpl_ready  (cmpl_ready),
    .cmpl_engine (cmpl_engine),
    .cmpl_id     (cmpl_id),
    .err_spurious(err_spurious)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .perf_dispatched(perf_dispatched),
    .perf_stall     (perf_stall),
    .perf_busy_max  (perf_busy_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model state.
  eng_state_t     m_stat [N];
  logic [IDW-1:0] m_id [N];
  logic [PW-1:0]  m_data;
  bit             m_issuing;
  int             m_ieng;
  int             m_last;
  bit             m_cv;
  int             m_ce;
  logic [IDW-1:0] m_cid;
  bit             m_err;
  int             run_left [N];
  int             ack_wait;

  // Values observed at the last sampling point.
  logic           obs_acc;
  logic [N-1:0]   obs_start;
  logic           obs_cv;
  logic [1:0]     obs_ce;
  logic [IDW-1:0] obs_cid;
  logic           obs_err;
  logic [PW-1:0]  obs_data;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_stat[i]   = E_FREE;
      run_left[i] = 0;
    end
    m_data    = '0;
    m_issuing = 0;
    m_ieng    = 0;
    m_last    = N - 1;
    m_cv      = 0;
    m_ce      = 0;
    m_cid     = '0;
    m_err     = 0;
    ack_wait  = 0;
  endtask

  function automatic bit model_any_free();
    for (int i = 0; i < N; i++) if (m_stat[i] == E_FREE) return 1;
    return 0;
  endfunction

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step(input logic v, input logic [IDW-1:0] id, input logic [N-1:0] ack,
                      input logic [N-1:0] done, input logic rdy, input logic r);
    logic [PW-1:0] d;
    logic          exp_acc;
    logic [N-1:0]  exp_start;
    eng_state_t    old [N];
    int            g;
    d = {$urandom, $urandom, $urandom, $urandom};
    rst        = r;
    cmd_valid  = v;
    cmd_id     = id;
    cmd_data   = d;
    eng_ack    = ack;
    eng_done   = done;
    cmpl_ready = rdy;

    exp_acc   = !r && !m_issuing && model_any_free();
    exp_start = m_issuing ? (N'(1) << m_ieng) : '0;

    @(negedge clk);
    obs_acc   = cmd_accept;
    obs_start = eng_start;
    obs_cv    = cmpl_valid;
    obs_ce    = cmpl_engine;
    obs_cid   = cmpl_id;
    obs_err   = err_spurious;
    obs_data  = eng_data;
    check("accept", PW'(cmd_accept), PW'(exp_acc));
    check("start", PW'(eng_start), PW'(exp_start));
    check("data", eng_data, m_data);
    check("cmpl_valid", PW'(cmpl_valid), PW'(m_cv));
    if (m_cv) begin
      check("cmpl_engine", PW'(cmpl_engine), PW'(m_ce));
      check("cmpl_id", PW'(cmpl_id), PW'(m_cid));
    end
    check("err", PW'(err_spurious), PW'(m_err));

    // Advance the model to the state after the coming edge.
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) old[i] = m_stat[i];
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if (old[i] == E_RUN) m_stat[i] = E_PEND;
          else                 m_err = 1;
        end
        if (ack[i] && !(m_issuing && i == m_ieng)) m_err = 1;
      end
      if (m_issuing && ack[m_ieng]) begin
        m_stat[m_ieng]   = E_RUN;
        run_left[m_ieng] = $urandom_range(1, 8);
        m_issuing        = 0;
      end
      if (m_cv && rdy) m_stat[m_ce] = E_FREE;
      if (v && exp_acc) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && old[(m_last + k) % N] == E_FREE) g = (m_last + k) % N;
        end
        m_issuing = 1;
        m_ieng    = g;
        m_id[g]   = id;
        m_data    = d;
        m_last    = g;
        ack_wait  = $urandom_range(1, 3);
      end
      if (!(m_cv && !rdy)) begin
        m_cv  = 0;
        m_ce  = 0;
        m_cid = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (m_stat[i] == E_PEND) begin
            m_cv  = 1;
            m_ce  = i;
            m_cid = m_id[i];
          end
        end
      end
    end

    @(posedge clk);
    #1;
  endtask

  // Offer one command and acknowledge it one cycle after start appears.
  task automatic issue(input logic [IDW-1:0] id, input logic [N-1:0] exp_onehot);
    step(1'b1, id, '0, '0, 1'b1, 1'b0);
    check("issue_accept", PW'(obs_acc), PW'(1'b1));
    step(1'b0, id, '0, '0, 1'b1, 1'b0);
    check("issue_start", PW'(obs_start), PW'(exp_onehot));
    step(1'b0, id, exp_onehot, '0, 1'b1, 1'b0);
  endtask

  // Well-behaved random engines and random command/consumer traffic.
  task automatic rand_cycle();
    logic [N-1:0] a;
    logic [N-1:0] dn;
    a  = '0;
    dn = '0;
    if (m_issuing) begin
      ack_wait--;
      if (ack_wait <= 0) a[m_ieng] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (m_stat[i] == E_RUN) begin
        run_left[i]--;
        if (run_left[i] <= 0) dn[i] = 1'b1;
      end
    end
    step(1'($urandom_range(0, 2) != 0), IDW'($urandom), a, dn,
         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
  endtask

  int exp_e3 [3] = '{0, 1, 3};
  int exp_i3 [3] = '{1, 2, 4};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_id = '0;
    eng_ack = '0; eng_done = '0; cmpl_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("rst_accept_low", PW'(obs_acc), PW'(1'b0));

    // 1: four commands go to engines 0..3 in order, fifth waits.
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("rst_start", PW'(obs_start), PW'(4'b0000));
    check("rst_cmpl_valid", PW'(obs_cv), PW'(1'b0));
    check("rst_err", PW'(obs_err), PW'(1'b0));
    check("rst_data", obs_data, '0);
    for (int k = 0; k < 4; k++) issue(IDW'(k + 1), N'(1) << k);
    step(1'b1, 10'd5, '0, '0, 1'b1, 1'b0);
    check("t1_full_accept", PW'(obs_acc), PW'(1'b0));

    // 2: engine 2 completes; its slot is reused only after the record drains.
    step(1'b1, 10'd5, '0, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 10'd5, '0, '0, 1'b1, 1'b0);
    check("t2_cv", PW'(obs_cv), PW'(1'b1));
    check("t2_ce", PW'(obs_ce), PW'(2));
    check("t2_cid", PW'(obs_cid), PW'(3));
    check("t2_acc_pend", PW'(obs_acc), PW'(1'b0));
    issue(10'd5, 4'b0100);

    // 3: simultaneous done on 0,1,3 drains lowest first on consecutive cycles.
    step(1'b0, '0, '0, 4'b1011, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      check("t3_cv", PW'(obs_cv), PW'(1'b1));
      check("t3_ce", PW'(obs_ce), PW'(exp_e3[k]));
      check("t3_cid", PW'(obs_cid), PW'(exp_i3[k]));
    end

    // 4: stalled completion on engine 1 holds steady and blocks re-grant.
    issue(10'd6, 4'b1000);
    issue(10'd7, 4'b0001);
    issue(10'd8, 4'b0010);
    step(1'b0, '0, '0, 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 10'd9, '0, '0, 1'b0, 1'b0);
      check("t4_ce", PW'(obs_ce), PW'(1));
      check("t4_cid", PW'(obs_cid), PW'(8));
      check("t4_start", PW'(obs_start), PW'(4'b0000));
    end
    step(1'b1, 10'd9, '0, '0, 1'b1, 1'b0);
    issue(10'd9, 4'b0010);

    // 5: spurious done and ack set the sticky error without side effects.
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    issue(10'd20, 4'b0001);
    step(1'b1, 10'd21, '0, '0, 1'b1, 1'b0);
    step(1'b0, 10'd21, '0, '0, 1'b1, 1'b0);
    check("t5_start", PW'(obs_start), PW'(4'b0010));
    step(1'b0, 10'd21, 4'b0001, 4'b1000, 1'b1, 1'b0);
    step(1'b0, 10'd21, '0, '0, 1'b1, 1'b0);
    check("t5_err", PW'(obs_err), PW'(1'b1));
    check("t5_still_start", PW'(obs_start), PW'(4'b0010));
    check("t5_no_cmpl", PW'(obs_cv), PW'(1'b0));
    step(1'b0, 10'd21, 4'b0010, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("t5_err_sticky", PW'(obs_err), PW'(1'b1));

    // 6: reset while an issue waits for ack drops everything.
    step(1'b1, 10'd22, '0, '0, 1'b1, 1'b0);
    step(1'b0, 10'd22, '0, '0, 1'b1, 1'b0);
    check("t6_start", PW'(obs_start), PW'(4'b0100));
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("t6_start_rst", PW'(obs_start), PW'(4'b0000));
    check("t6_err_rst", PW'(obs_err), PW'(1'b0));
    check("t6_cv_rst", PW'(obs_cv), PW'(1'b0));
    check("t6_ce_rst", PW'(obs_ce), PW'(0));
    check("t6_cid_rst", PW'(obs_cid), PW'(0));
    check("t6_data_rst", obs_data, '0);
    check("t6_acc", PW'(obs_acc), PW'(1'b1));
    issue(10'd23, 4'b0001);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) rand_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
